// File: rtl/barrett_precompute_64b_pkg.sv
// barrett_precompute_64b_pkg: shared widths and FSM state encoding for the Barrett constant generator
package barrett_precompute_64b_pkg;
  localparam int BARRETT_W  = 64;
  localparam int BARRETT_KW = 7;
  localparam int BARRETT_UW = 128;
  localparam int QW         = BARRETT_W + 2;
  localparam int CW         = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_SIZE, ST_DIV, ST_DONE} state_t;
endpackage

// File: rtl/barrett_precompute_64b_msb_index.sv
// barrett_precompute_64b_msb_index: combinational leading-one detector for a 64-bit word
module barrett_precompute_64b_msb_index
  import barrett_precompute_64b_pkg::*;
(
  input  logic [BARRETT_W-1:0] i_in,
  output logic [5:0]           o_idx,
  output logic                 o_zero
);
  // highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < BARRETT_W; i++) if (i_in[i]) o_idx = 6'(i);
  end
  assign o_zero = ~|i_in;
endmodule

// File: rtl/barrett_precompute_64b.sv
// barrett_precompute_64b: K = bitlen(M), U = floor(2^(2K)/M) by radix-2 restoring division
module barrett_precompute_64b
  import barrett_precompute_64b_pkg::*;
(
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iEn,
  input  logic                  iClr,
  input  logic                  iStart,
  input  logic [BARRETT_W-1:0]  iMod,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr,
  output logic [BARRETT_KW-1:0] oK,
  output logic [BARRETT_UW-1:0] oU
);
  state_t                r_state;
  logic [BARRETT_W-1:0]  r_m;
  logic [BARRETT_W-1:0]  r_r;
  logic [QW-1:0]         r_q;
  logic [QW-1:0]         r_u;
  logic [BARRETT_KW-1:0] r_k;
  logic [BARRETT_KW-1:0] r_ok;
  logic [CW-1:0]         r_cnt;
  logic                  r_err;
  logic                  r_oerr;
  logic                  r_busy;
  logic                  r_done;
  logic [5:0]            w_idx;
  logic                  w_zero;
  logic [BARRETT_KW-1:0] w_k;
  logic [BARRETT_W:0]    w_rs;
  logic                  w_ge;
  barrett_precompute_64b_msb_index u_msb (
    .i_in  (r_m),
    .o_idx (w_idx),
    .o_zero(w_zero)
  );
  assign w_k  = w_zero ? '0 : BARRETT_KW'(w_idx) + 7'd1;
  // the dividend 2^(2K) is fed MSB-first: a single 1 on the first iteration, zeros after
  assign w_rs = {r_r, r_cnt == {r_k, 1'b0}};
  assign w_ge = w_rs >= {1'b0, r_m};
  // FSM and division datapath; the remainder stays below M so 64 bits hold it between steps
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_u     <= '0;
      r_k     <= '0;
      r_ok    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_oerr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (iClr) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_u     <= '0;
      r_k     <= '0;
      r_ok    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_oerr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (iEn) begin
      r_done <= r_state == ST_DONE;
      case (r_state)
        ST_IDLE: if (iStart) begin
          r_m     <= iMod;
          r_busy  <= 1'b1;
          r_state <= ST_SIZE;
        end
        ST_SIZE: begin
          r_k     <= w_k;
          r_cnt   <= {w_k, 1'b0};
          r_r     <= '0;
          r_q     <= '0;
          r_err   <= w_zero;
          r_state <= w_zero ? ST_DONE : ST_DIV;
        end
        ST_DIV: begin
          r_r     <= w_ge ? w_rs[BARRETT_W-1:0] - r_m : w_rs[BARRETT_W-1:0];
          r_q     <= {r_q[QW-2:0], w_ge};
          r_cnt   <= r_cnt - 8'd1;
          r_state <= r_cnt == '0 ? ST_DONE : ST_DIV;
        end
        default: begin
          r_ok    <= r_k;
          r_u     <= r_q;
          r_oerr  <= r_err;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
  assign oBusy = r_busy;
  assign oDone = r_done;
  assign oErr  = r_oerr;
  assign oK    = r_ok;
  assign oU    = {{(BARRETT_UW-QW){1'b0}}, r_u};
endmodule

// File: tb/tb_barrett_precompute_64b.sv
// tb_barrett_precompute_64b: directed and random checks of K/U against an arithmetic reference
module tb_barrett_precompute_64b;
  logic         iClk = 1'b0;
  logic         iRstN = 1'b0;
  logic         iEn = 1'b1;
  logic         iClr = 1'b0;
  logic         iStart = 1'b0;
  logic [63:0]  iMod = '0;
  logic         oBusy, oDone, oErr;
  logic [6:0]   oK;
  logic [127:0] oU;
  int n_pass = 0;
  int n_total = 0;

  barrett_precompute_64b dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iStart(iStart),
    .iMod(iMod), .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oK(oK), .oU(oU)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ref_k(input logic [63:0] m);
    int k = 0;
    while (k < 64 && (m >> k) != 64'd0) k++;
    return k;
  endfunction

  function automatic logic [131:0] ref_u(input logic [63:0] m);
    logic [131:0] num;
    if (m == 64'd0) return '0;
    num = 132'd1 << (2 * ref_k(m));
    return num / {68'd0, m};
  endfunction

  // start M, count edges to oDone; optional iEn gap and an ignored restart with M=13
  task automatic run_one(input logic [63:0] m, input int gap_at, input int gap_len, input int ign_at);
    int n = 0;
    int k = ref_k(m);
    int exp_lat = (m == 64'd0) ? 2 : 2 * k + 3 + gap_len;
    @(negedge iClk);
    iMod = m;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    iMod = $urandom;
    while (n < 400) begin
      @(posedge iClk);
      #1;
      n++;
      if (oDone) break;
      if (gap_at > 0 && n == gap_at) iEn = 1'b0;
      if (gap_at > 0 && n == gap_at + gap_len) iEn = 1'b1;
      if (ign_at > 0 && n == ign_at) begin
        iMod = 64'd13;
        iStart = 1'b1;
      end else iStart = 1'b0;
    end
    iEn = 1'b1;
    iStart = 1'b0;
    chk($sformatf("lat_%0h", m), 132'(n), 132'(exp_lat));
    chk($sformatf("k_%0h", m), 132'(oK), 132'(k));
    chk($sformatf("u_%0h", m), 132'(oU), ref_u(m));
    chk($sformatf("err_%0h", m), 132'(oErr), 132'(m == 64'd0));
    chk($sformatf("busy_%0h", m), 132'(oBusy), 132'd0);
    @(posedge iClk);
    #1;
    chk($sformatf("pulse_%0h", m), 132'(oDone), 132'd0);
  endtask

  // use the DUT's K/U for a Barrett reduction of a*b and compare with a plain modulo
  task automatic barrett_chk(input logic [63:0] m);
    logic [63:0]  a, b;
    logic [131:0] x, q, r;
    int k = int'(oK);
    for (int t = 0; t < 3; t++) begin
      a = {$urandom, $urandom} % m;
      b = {$urandom, $urandom} % m;
      x = {68'd0, a} * {68'd0, b};
      q = (((x >> (k - 1)) * {4'd0, oU}) >> (k + 1));
      r = x - q * {68'd0, m};
      for (int s = 0; s < 4 && r >= {68'd0, m}; s++) r = r - {68'd0, m};
      chk($sformatf("barrett_%0h", m), r, x % {68'd0, m});
    end
  endtask

  initial begin
    logic [63:0] m;
    logic saw;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_busy", 132'(oBusy), 132'd0);
    chk("rst_done", 132'(oDone), 132'd0);
    chk("rst_k", 132'(oK), 132'd0);
    chk("rst_u", 132'(oU), 132'd0);
    @(negedge iClk);
    iRstN = 1'b1;
    run_one(64'd7, 0, 0, 0);
    chk("m7_u_const", 132'(oU), 132'd9);
    run_one(64'd13, 0, 0, 0);
    chk("m13_u_const", 132'(oU), 132'd19);
    run_one(64'd1, 0, 0, 0);
    chk("m1_u_const", 132'(oU), 132'd4);
    run_one(64'hFFFF_FFFF_FFFF_FFC5, 0, 0, 0);
    chk("big_u_const", 132'(oU), 132'h1_0000_0000_0000_003B);
    barrett_chk(64'hFFFF_FFFF_FFFF_FFC5);
    run_one(64'h8000_0000_0000_0000, 0, 0, 0);
    chk("pow2_bit65", 132'(oU[65]), 132'd1);
    barrett_chk(64'h8000_0000_0000_0000);
    run_one(64'd0, 0, 0, 0);
    run_one(64'd7, 0, 0, 3);
    run_one(64'd13, 5, 5, 0);
    @(negedge iClk);
    iMod = 64'd13;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    iClr = 1'b1;
    @(posedge iClk);
    #1;
    iClr = 1'b0;
    chk("clr_busy", 132'(oBusy), 132'd0);
    chk("clr_k", 132'(oK), 132'd0);
    chk("clr_u", 132'(oU), 132'd0);
    chk("clr_err", 132'(oErr), 132'd0);
    saw = 1'b0;
    repeat (30) begin
      @(posedge iClk);
      #1;
      saw = saw | oDone;
    end
    chk("clr_no_done", 132'(saw), 132'd0);
    for (int j = 0; j < 8; j++) begin
      m = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (m == 64'd0) m = 64'd3;
      run_one(m, 0, 0, 0);
      barrett_chk(m);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
